// File: rtl/multiword_add_seq.sv
// WIDTH-bit add/subtract by time-sharing one SLICE-bit adder, LS slice first, carry rippled via a register.
// Optional flag outputs (OF/SF/ZF/CF) are built only when SPU_ADD_FLAGS_EN is defined.
module multiword_add_seq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic [WIDTH-1:0] F,
  output logic             Cout,
  output logic             OF,
  output logic             SF,
  output logic             ZF,
  output logic             CF,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state,       w_state_d;
  logic [WIDTH-1:0] r_a,           w_a_d;
  logic [WIDTH-1:0] r_bx,          w_bx_d;
  logic             r_carry,       w_carry_d;
  logic [IDX_W-1:0] r_idx,         w_idx_d;
  logic [WIDTH-1:0] r_f,           w_f_d;
  logic             r_cout,        w_cout_d;
  logic             r_start_ready, w_start_ready_d;
  logic             r_done_valid,  w_done_valid_d;
  logic             r_busy,        w_busy_d;

  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE:0]   w_sum;
  logic [WIDTH-1:0] w_f_new;
  logic             w_last;
  logic             w_accept;

  // Operand slice select and the shared slice adder
  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int unsigned k = 0; k < NSLICE; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_sl = r_a[k*SLICE +: SLICE];
        w_b_sl = r_bx[k*SLICE +: SLICE];
      end
    end
  end

  assign w_sum    = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_carry};
  assign w_last   = (r_idx == IDX_W'(NSLICE - 1));
  assign w_accept = start_valid & r_start_ready;

  // Result register with the current slice written in place
  always_comb begin
    w_f_new = r_f;
    for (int unsigned k = 0; k < NSLICE; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_f_new[k*SLICE +: SLICE] = w_sum[SLICE-1:0];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_d = r_state;
    w_a_d     = r_a;
    w_bx_d    = r_bx;
    w_carry_d = r_carry;
    w_idx_d   = r_idx;
    w_f_d     = r_f;
    w_cout_d  = r_cout;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_a_d     = A;
          w_bx_d    = Sub ? ~B : B;
          w_carry_d = Sub;
          w_idx_d   = '0;
          w_state_d = S_RUN;
        end
      end
      S_RUN: begin
        w_f_d     = w_f_new;
        w_carry_d = w_sum[SLICE];
        w_idx_d   = r_idx + IDX_W'(1);
        if (w_last) begin
          w_cout_d  = w_sum[SLICE];
          w_state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (done_ready) begin
          w_state_d = S_IDLE;
        end
      end
      default: w_state_d = S_IDLE;
    endcase
    w_start_ready_d = (w_state_d == S_IDLE);
    w_done_valid_d  = (w_state_d == S_DONE);
    w_busy_d        = (w_state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_a           <= '0;
      r_bx          <= '0;
      r_carry       <= 1'b0;
      r_idx         <= '0;
      r_f           <= '0;
      r_cout        <= 1'b0;
      r_start_ready <= 1'b0;
      r_done_valid  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_a           <= w_a_d;
      r_bx          <= w_bx_d;
      r_carry       <= w_carry_d;
      r_idx         <= w_idx_d;
      r_f           <= w_f_d;
      r_cout        <= w_cout_d;
      r_start_ready <= w_start_ready_d;
      r_done_valid  <= w_done_valid_d;
      r_busy        <= w_busy_d;
    end
  end

`ifdef SPU_ADD_FLAGS_EN
  logic r_sub, w_sub_d;
  logic r_of,  w_of_d;
  logic r_sf,  w_sf_d;
  logic r_zf,  w_zf_d;
  logic r_cf,  w_cf_d;

  // Flags are captured only on the final slice, alongside Cout
  always_comb begin
    w_sub_d = r_sub;
    w_of_d  = r_of;
    w_sf_d  = r_sf;
    w_zf_d  = r_zf;
    w_cf_d  = r_cf;
    if ((r_state == S_IDLE) && w_accept) begin
      w_sub_d = Sub;
    end
    if ((r_state == S_RUN) && w_last) begin
      w_of_d = (r_a[WIDTH-1] == r_bx[WIDTH-1]) & (w_sum[SLICE-1] != r_a[WIDTH-1]);
      w_sf_d = w_sum[SLICE-1];
      w_zf_d = (w_f_new == '0);
      w_cf_d = w_sum[SLICE] ^ r_sub;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub <= 1'b0;
      r_of  <= 1'b0;
      r_sf  <= 1'b0;
      r_zf  <= 1'b0;
      r_cf  <= 1'b0;
    end else begin
      r_sub <= w_sub_d;
      r_of  <= w_of_d;
      r_sf  <= w_sf_d;
      r_zf  <= w_zf_d;
      r_cf  <= w_cf_d;
    end
  end

  assign OF = r_of;
  assign SF = r_sf;
  assign ZF = r_zf;
  assign CF = r_cf;
`else
  assign OF = 1'b0;
  assign SF = 1'b0;
  assign ZF = 1'b0;
  assign CF = 1'b0;
`endif

  assign start_ready = r_start_ready;
  assign done_valid  = r_done_valid;
  assign busy        = r_busy;
  assign F           = r_f;
  assign Cout        = r_cout;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: directed corner cases plus random ops against a plain-arithmetic model.
module tb_multiword_add_seq;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Sub;
  logic [W-1:0] F;
  logic         Cout, OF, SF, ZF, CF;
  logic         done_valid;
  logic         done_ready;
  logic         busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] e_f;
  logic         e_cout, e_of, e_sf, e_zf, e_cf;

  multiword_add_seq #(.WIDTH(64), .SLICE(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .A(A), .B(B), .Sub(Sub),
    .F(F), .Cout(Cout), .OF(OF), .SF(SF), .ZF(ZF), .CF(CF),
    .done_valid(done_valid), .done_ready(done_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: full-width arithmetic, signed overflow via a widened signed result
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0]        wide_u;
    logic signed [W:0] wide_s;
    if (sub) begin
      e_f    = a - b;
      e_cout = (a >= b);
      wide_s = $signed({a[W-1], a}) - $signed({b[W-1], b});
    end else begin
      wide_u = {1'b0, a} + {1'b0, b};
      e_f    = wide_u[W-1:0];
      e_cout = wide_u[W];
      wide_s = $signed({a[W-1], a}) + $signed({b[W-1], b});
    end
`ifdef SPU_ADD_FLAGS_EN
    e_of = (wide_s[W] != wide_s[W-1]);
    e_sf = e_f[W-1];
    e_zf = (e_f == '0);
    e_cf = e_cout ^ sub;
`else
    e_of = 1'b0;
    e_sf = 1'b0;
    e_zf = 1'b0;
    e_cf = 1'b0;
`endif
  endtask

  task automatic check_result(input string tag);
    check({tag, ".F"},    F,    e_f);
    check({tag, ".Cout"}, 64'(Cout), 64'(e_cout));
    check({tag, ".flags"}, 64'({OF, SF, ZF, CF}), 64'({e_of, e_sf, e_zf, e_cf}));
    check({tag, ".dv"},   64'(done_valid), 64'(1));
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int n = 0;
    while (!start_ready && n < 20) begin
      tick();
      n++;
    end
    A = a; B = b; Sub = sub;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    model(a, b, sub);
  endtask

  // Counts edges from the accepting edge until done_valid is seen (bounded)
  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!done_valid && cyc < 12) begin
      tick();
      cyc++;
    end
    check({tag, ".lat"}, 64'(cyc), 64'(4));
  endtask

  task automatic consume(input string tag);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check({tag, ".dv_clr"}, 64'({done_valid, start_ready, busy}), 64'(3'b010));
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input int hold);
    issue(a, b, sub);
    check({tag, ".busy"}, 64'({busy, start_ready}), 64'(2'b10));
    wait_done(tag);
    check_result(tag);
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'b1;
      A = ~a;
      tick();
      start_valid = 1'b0;
      check({tag, ".hold_sr"}, 64'(start_ready), 64'(0));
      check_result({tag, ".hold"});
    end
    consume(tag);
  endtask

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
    A = '0; B = '0; Sub = 1'b0;
    #2;
    check("rst.F", F, 64'(0));
    check("rst.outs", 64'({Cout, OF, SF, ZF, CF, done_valid, start_ready, busy}), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    check("rst.sr_pre", 64'(start_ready), 64'(0));
    tick();
    check("rst.sr_post", 64'(start_ready), 64'(1));

    do_op("t1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
    do_op("t2", 64'd5, 64'd7, 1'b1, 0);
    do_op("t3", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
    do_op("t4", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 5);

    // Consume and start in the same cycle: start waits one cycle
    issue(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0);
    wait_done("t4b");
    check_result("t4b");
    A = 64'h0000_FFFF_0000_FFFF; B = 64'h0000_0001_0000_0001; Sub = 1'b0;
    done_ready = 1'b1;
    start_valid = 1'b1;
    tick();
    done_ready = 1'b0;
    check("t4b.noacc", 64'({done_valid, start_ready, busy}), 64'(3'b010));
    tick();
    start_valid = 1'b0;
    check("t4b.acc", 64'({start_ready, busy}), 64'(2'b01));
    model(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0);
    wait_done("t4c");
    check_result("t4c");
    consume("t4c");

    // Reset mid-operation
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("t5.F", F, 64'(0));
    check("t5.outs", 64'({Cout, OF, SF, ZF, CF, done_valid, start_ready, busy}), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    check("t5.sr", 64'({start_ready, busy}), 64'(2'b10));
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t5.no_dv", 64'(done_valid), 64'(0));
    end

    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] ra, rb;
      ra = {$urandom(), $urandom()};
      rb = (i % 4 == 3) ? ra : {$urandom(), $urandom()};
      do_op("rnd", ra, rb, 1'($urandom_range(1, 0)), int'($urandom_range(2, 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
